// File: rtl/pixel_pkg.sv
// Shared frame-buffer constants and pixel type for the VGA path.
// Frame is 320x200 RGB444; one word per pixel at address y*320+x.
package pixel_pkg;

   localparam int unsigned PIX_W     = 12;
   localparam int unsigned FB_W      = 320;
   localparam int unsigned FB_H      = 200;
   localparam int unsigned FB_DEPTH  = FB_W * FB_H;
   localparam int unsigned FB_ADDR_W = 16;

   typedef struct packed {
      logic [3:0] b;
      logic [3:0] g;
      logic [3:0] r;
   } pixel_t;

   typedef enum logic {
      StIdle,
      StClear
   } clr_state_e;

   // Linear frame-buffer address of pixel (x, y).
   function automatic logic [FB_ADDR_W-1:0] pix_addr(input int unsigned x, input int unsigned y);
      return FB_ADDR_W'(y * FB_W + x);
   endfunction

endpackage

// File: rtl/pixel_array_ram_if.sv
// Bus bundle for the frame-buffer RAM.
//   data/wraddress/wren : write port (CPU side)
//   rdaddress/q         : read port (scan side), q registered
//   busy                : clear sweep in progress
interface pixel_array_ram_if
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_W = PIX_W,
   parameter int unsigned ADDR_W = FB_ADDR_W
);

   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] wraddress;
   logic              wren;
   logic [ADDR_W-1:0] rdaddress;
   logic [DATA_W-1:0] q;
   logic              busy;

   modport master (
      output data, wraddress, wren, rdaddress,
      input  q, busy
   );

   modport slave (
      input  data, wraddress, wren, rdaddress,
      output q, busy
   );

endinterface

// File: rtl/pixel_ram_core.sv
// Plain simple dual-port RAM: one write port, one registered read port, no reset,
// so it maps onto block RAM. Read-during-write to the same address returns old data.
//   clk_i   : clock
//   we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o       : read port, 1-cycle latency
module pixel_ram_core
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_W = PIX_W,
   parameter int unsigned ADDR_W = FB_ADDR_W,
   parameter int unsigned DEPTH  = FB_DEPTH
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_array_ram.sv
// Frame-buffer storage: simple dual-port RAM with range checking, optional
// post-reset clear sweep and zero-masked read data.
//   main_clk : single clock
//   reset    : synchronous, active-high
//   bus      : slave side of pixel_array_ram_if (write port, read port, busy)
module pixel_array_ram
   import pixel_pkg::*;
#(
   parameter int unsigned       DATA_W         = PIX_W,
   parameter int unsigned       ADDR_W         = FB_ADDR_W,
   parameter int unsigned       DEPTH          = FB_DEPTH,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
   input  logic             main_clk,
   input  logic             reset,
   pixel_array_ram_if.slave bus
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   // Initialised so q reads 0 from power-up even without a reset.
   logic              rd_ok_q = 1'b0;
   logic              rd_ok_d;

   logic              busy;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   assign busy        = (state_q == StClear);
   assign wr_in_range = (32'(bus.wraddress) < DEPTH);
   assign rd_in_range = (32'(bus.rdaddress) < DEPTH);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      ram_we    = 1'b0;
      ram_waddr = bus.wraddress;
      ram_wdata = bus.data;
      // Flag travels alongside the RAM read so the mask lines up with q.
      rd_ok_d   = rd_in_range && !busy;
      unique case (state_q)
         StIdle: begin
            ram_we = bus.wren && wr_in_range;
         end
         StClear: begin
            // Sweep owns the write port; user writes are dropped while busy.
            ram_we    = !reset;
            ram_waddr = ptr_q;
            ram_wdata = CLEAR_VALUE;
            if (ptr_q == LastAddr) begin
               state_d = StIdle;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge main_clk) begin
      if (reset) begin
         state_q <= CLEAR_ON_RESET ? StClear : StIdle;
         ptr_q   <= '0;
         rd_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rd_ok_q <= rd_ok_d;
      end
   end

   pixel_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .clk_i   (main_clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (bus.rdaddress),
      .rdata_o (ram_rdata)
   );

   assign bus.q    = rd_ok_q ? ram_rdata : '0;
   assign bus.busy = busy;

endmodule

// File: tb/tb_pixel_array_ram.sv
module tb_pixel_array_ram;
   import pixel_pkg::*;

   localparam int unsigned DEPTH = FB_DEPTH;

   logic clk = 1'b0;
   logic rst1;
   logic rst0;

   always #5 clk = ~clk;

   pixel_array_ram_if #(.DATA_W(PIX_W), .ADDR_W(FB_ADDR_W)) bus1 ();
   pixel_array_ram_if #(.DATA_W(PIX_W), .ADDR_W(FB_ADDR_W)) bus0 ();

   pixel_array_ram #(.CLEAR_ON_RESET(1'b1)) dut1 (
      .main_clk (clk),
      .reset    (rst1),
      .bus      (bus1.slave)
   );

   pixel_array_ram #(.CLEAR_ON_RESET(1'b0)) dut0 (
      .main_clk (clk),
      .reset    (rst0),
      .bus      (bus0.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference contents of dut1 after its clear sweep.
   logic [11:0] model [DEPTH];

   typedef struct {
      logic        we;
      logic [15:0] wa;
      logic [11:0] wd;
      logic [15:0] ra;
      logic [11:0] exp_q;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle on dut1 (idle, not busy): expected q comes from the model before the write.
   task automatic cyc1(input logic we, input logic [15:0] wa, input logic [11:0] wd,
                       input logic [15:0] ra, input string name);
      logic [11:0] exp;
      exp = (ra < DEPTH) ? model[ra] : 12'h000;
      bus1.wren      = we;
      bus1.wraddress = wa;
      bus1.data      = wd;
      bus1.rdaddress = ra;
      tick();
      if (we && (wa < DEPTH)) model[wa] = wd;
      check(name, 32'(bus1.q), 32'(exp));
   endtask

   initial begin
      int n;
      int busy_cnt;
      logic        rwe;
      logic [15:0] rwa;
      logic [15:0] rra;

      vecs[0] = '{1'b1, 16'd100,   12'hABC, 16'd100,   12'h000};
      vecs[1] = '{1'b0, 16'd0,     12'h000, 16'd100,   12'hABC};
      vecs[2] = '{1'b1, 16'd500,   12'h0F0, 16'd0,     12'h000};
      vecs[3] = '{1'b1, 16'd500,   12'h123, 16'd500,   12'h0F0};
      vecs[4] = '{1'b0, 16'd0,     12'h000, 16'd500,   12'h123};
      vecs[5] = '{1'b1, 16'd64000, 12'hFFF, 16'd65535, 12'h000};
      vecs[6] = '{1'b0, 16'd0,     12'h000, 16'd0,     12'h000};
      vecs[7] = '{1'b0, 16'd0,     12'h000, 16'd63999, 12'h000};
      vecs[8] = '{1'b1, 16'd65535, 12'h555, 16'd64000, 12'h000};
      vecs[9] = '{1'b0, 16'd0,     12'h000, 16'd100,   12'hABC};

      for (int i = 0; i < int'(DEPTH); i++) model[i] = 12'h000;

      bus1.wren = 1'b0; bus1.wraddress = '0; bus1.data = '0; bus1.rdaddress = '0;
      bus0.wren = 1'b0; bus0.wraddress = '0; bus0.data = '0; bus0.rdaddress = '0;
      rst1 = 1'b1;
      rst0 = 1'b1;
      tick();
      tick();
      check("reset_busy1", 32'(bus1.busy), 32'd1);
      check("reset_busy0", 32'(bus0.busy), 32'd0);
      check("reset_q1", 32'(bus1.q), 32'd0);
      check("reset_q0", 32'(bus0.q), 32'd0);
      rst1 = 1'b0;
      rst0 = 1'b0;

      // Let the first sweep run 1000 cycles, then restart it.
      busy_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (bus1.busy) busy_cnt++;
      end
      check("sweep_pre_busy", 32'(busy_cnt), 32'd1000);
      rst1 = 1'b1;
      tick();
      check("restart_busy", 32'(bus1.busy), 32'd1);
      rst1 = 1'b0;

      // Full-length sweep after restart; a write mid-sweep must be dropped.
      n = 0;
      for (;;) begin
         bus1.wren      = (n == 500);
         bus1.wraddress = 16'd100;
         bus1.data      = 12'hFFF;
         bus1.rdaddress = 16'd0;
         tick();
         n++;
         if (n == 501) check("busy_read_zero", 32'(bus1.q), 32'd0);
         if (!bus1.busy || n >= 70000) break;
      end
      check("busy_len", 32'(n), 32'd64000);
      bus1.wren = 1'b0;

      cyc1(1'b0, 16'd0, 12'h000, 16'd0, "clear_0");
      cyc1(1'b0, 16'd0, 12'h000, 16'd31999, "clear_31999");
      cyc1(1'b0, 16'd0, 12'h000, pix_addr(319, 199), "clear_63999");
      cyc1(1'b0, 16'd0, 12'h000, 16'd100, "busy_write_dropped");
      check("idle_busy", 32'(bus1.busy), 32'd0);

      for (int i = 0; i < 10; i++) begin
         bus1.wren      = vecs[i].we;
         bus1.wraddress = vecs[i].wa;
         bus1.data      = vecs[i].wd;
         bus1.rdaddress = vecs[i].ra;
         tick();
         if (vecs[i].we && (vecs[i].wa < DEPTH)) model[vecs[i].wa] = vecs[i].wd;
         check($sformatf("vec%0d", i), 32'(bus1.q), 32'(vecs[i].exp_q));
      end

      // Back-to-back scan of one line.
      for (int i = 0; i < 320; i++) cyc1(1'b1, 16'(i), 12'(i), 16'd0, "scan_fill");
      for (int i = 0; i < 320; i++) begin
         bus1.wren      = 1'b0;
         bus1.rdaddress = 16'(i);
         tick();
         check("scan_read", 32'(bus1.q), 32'(i));
      end

      // Random traffic against the array model.
      for (int i = 0; i < 3000; i++) begin
         rwe = 1'($urandom_range(0, 1));
         rwa = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 1023))
                                            : 16'($urandom_range(0, 65535));
         rra = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 1023))
                                            : 16'($urandom_range(0, 65535));
         cyc1(rwe, rwa, 12'($urandom), rra, "random");
      end
      bus1.wren = 1'b0;

      // CLEAR_ON_RESET=0: contents survive reset, busy never rises.
      bus0.wren      = 1'b1;
      bus0.wraddress = 16'd42;
      bus0.data      = 12'h2A5;
      bus0.rdaddress = 16'd42;
      tick();
      bus0.wren = 1'b0;
      tick();
      check("noclr_write", 32'(bus0.q), 32'h2A5);
      rst0 = 1'b1;
      tick();
      check("noclr_reset_q", 32'(bus0.q), 32'd0);
      check("noclr_reset_busy", 32'(bus0.busy), 32'd0);
      rst0 = 1'b0;
      tick();
      check("noclr_busy", 32'(bus0.busy), 32'd0);
      check("noclr_survive", 32'(bus0.q), 32'h2A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
